// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
// Holds the divider FSM state encoding, the default operand width and a
// helper that sizes the iteration counter so it can hold the value WIDTH.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIM  = 2'b10
  } div_state_t;

  // Counter must represent 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   i_rem      current partial remainder (always < divisor)
//   i_dvd_msb  next dividend bit shifted into the remainder
//   i_divisor  divisor
//   o_rem      partial remainder after this iteration
//   o_q_bit    quotient bit produced by this iteration
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dvd_msb,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH:0]   w_diff;

  // Dropping i_rem's MSB is safe: after k iterations the remainder is
  // bounded by the top k dividend bits, so the shifted value fits in WIDTH.
  assign w_shifted = {i_rem[WIDTH-2:0], i_dvd_msb};

  // WIDTH+1-bit subtract; a clear borrow bit means shifted >= divisor.
  assign w_diff  = {1'b0, w_shifted} - {1'b0, i_divisor};
  assign o_q_bit = ~w_diff[WIDTH];
  assign o_rem   = o_q_bit ? w_diff[WIDTH-1:0] : w_shifted;

endmodule

// File: rtl/binary_divider.sv
// Sequential unsigned restoring divider: QUOCIENTE = A / B, RESTO = A % B,
// one quotient bit per clock, START/BUSY/DONE handshake.
// Ports:
//   CLK        rising-edge clock
//   RESET_N    asynchronous active-low reset
//   START      operation request, sampled only in IDLE
//   A, B       dividend / divisor, sampled on the accepting edge
//   QUOCIENTE  registered quotient (all ones when B was zero)
//   RESTO      registered remainder (A when B was zero)
//   BUSY       high while iterating
//   DONE       one-cycle completion pulse
//   DIV_ZERO   registered flag: last accepted operation had B == 0
module binary_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] QUOCIENTE,
  output logic [WIDTH-1:0] RESTO,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_ZERO
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  div_state_t       r_state;
  div_state_t       w_next_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;       // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] r_divisor;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quociente;
  logic [WIDTH-1:0] r_resto;
  logic             r_div_zero;

  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic             w_b_zero;
  logic             w_last;

  assign w_b_zero = (B == {WIDTH{1'b0}});
  assign w_last   = (r_cnt == CNT_LAST);

  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_dvd_msb (r_dvd[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_next_state = w_b_zero ? FIM : CALC;
        end else begin
          w_next_state = IDLE;
        end
      end
      CALC: begin
        if (w_last) begin
          w_next_state = FIM;
        end else begin
          w_next_state = CALC;
        end
      end
      FIM:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State register; BUSY/DONE are registered from the next state so they
  // come straight off flops.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == CALC);
      r_done  <= (w_next_state == FIM);
    end
  end

  // Working registers, iteration counter and result registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rem       <= {WIDTH{1'b0}};
      r_dvd       <= {WIDTH{1'b0}};
      r_divisor   <= {WIDTH{1'b0}};
      r_cnt       <= {CNT_W{1'b0}};
      r_quociente <= {WIDTH{1'b0}};
      r_resto     <= {WIDTH{1'b0}};
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (START) begin
            r_dvd     <= A;
            r_divisor <= B;
            r_rem     <= {WIDTH{1'b0}};
            r_cnt     <= CNT_LOAD;
            if (w_b_zero) begin
              r_quociente <= {WIDTH{1'b1}};
              r_resto     <= A;
              r_div_zero  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt - CNT_LAST;
          if (w_last) begin
            r_quociente <= {r_dvd[WIDTH-2:0], w_q_bit};
            r_resto     <= w_rem_next;
            r_div_zero  <= 1'b0;
          end
        end
        FIM: begin
          r_cnt <= {CNT_W{1'b0}};
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign QUOCIENTE = r_quociente;
  assign RESTO     = r_resto;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign DIV_ZERO  = r_div_zero;

endmodule
